pipe_stage_reg: RTL and testbench

Generic, parametrised inter-stage pipeline register for the RV32I core. It supersedes the fixed per-stage registers (IF/ID, ID/EX, EX/MEM) with one elastic block.
- Carries PC, instruction, an opaque datapath payload and a zeroable control bundle.
- Uses a valid/ready handshake.
- Supports hazard bubble injection (kill) and misprediction redirect (flush).
- Optional skid entry decouples in_ready from out_ready timing.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/pipe_stage_reg_slot.sv | 89 ++++++++
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and control-bundle layout for the RV32I inter-stage pipeline registers.
package pipe_pkg;

   localparam int PC_W   = 13;
   localparam int INST_W = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   localparam int ALU_CODE_W      = 6;
   localparam int ALU_SRC_W       = 1;
   localparam int JUMP_CODE_W     = 2;
   localparam int BRANCH_CODE_W   = 3;
   localparam int MEM_STORE_W     = 2;
   localparam int MEM_LOAD_W      = 3;
   localparam int REG_WRITE_W     = 1;
   localparam int CANNOT_CALCPC_W = 1;
   localparam int CTRL_W = ALU_CODE_W + ALU_SRC_W + JUMP_CODE_W + BRANCH_CODE_W +
                           MEM_STORE_W + MEM_LOAD_W + REG_WRITE_W + CANNOT_CALCPC_W;

   localparam int IF_ID_DATA_W  = 1;
   localparam int ID_EX_DATA_W  = 101;
   localparam int EX_MEM_DATA_W = 69;

   typedef struct packed {
      logic [ALU_CODE_W-1:0]      alu_code;
      logic [ALU_SRC_W-1:0]       alu_src;
      logic [JUMP_CODE_W-1:0]     jump_code;
      logic [BRANCH_CODE_W-1:0]   branch_code;
      logic [MEM_STORE_W-1:0]     mem_store;
      logic [MEM_LOAD_W-1:0]      mem_load;
      logic [REG_WRITE_W-1:0]     reg_write;
      logic [CANNOT_CALCPC_W-1:0] cannot_calcpc;
   } ctrl_t;

   function automatic logic [CTRL_W-1:0] pack_ctrl(input ctrl_t c);
      return c;
   endfunction

   function automatic ctrl_t unpack_ctrl(input logic [CTRL_W-1:0] v);
      return ctrl_t'(v);
   endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry: valid, bubble flag, PC, instruction, payload and control bundle.
// Update priority is flush-load, then load, then clear.
module pipe_slot #(
   parameter int PC_W   = 13,
   parameter int INST_W = 32,
   parameter int DATA_W = 101,
   parameter int CTRL_W = 19,
   parameter logic [INST_W-1:0] NOP_INST = '0,
   parameter int FLUSH_PC_OFS = 2
) (
   input  logic              CLK,
   input  logic              NRST,
   input  logic              load_i,
   input  logic              kill_i,
   input  logic              flush_i,
   input  logic              clr_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [INST_W-1:0] inst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [PC_W-1:0]   flush_pc_i,
   output logic              valid_o,
   output logic              bubble_o,
   output logic [PC_W-1:0]   pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o
);
   import pipe_pkg::*;

   logic              valid_q, valid_d;
   logic              bubble_q, bubble_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   always_comb begin
      valid_d  = valid_q;
      bubble_d = bubble_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      data_d   = data_q;
      ctrl_d   = ctrl_q;
      if (flush_i) begin
         // Payload is deliberately left alone on a redirect.
         valid_d  = 1'b1;
         bubble_d = 1'b1;
         pc_d     = flush_pc_i - PC_W'(FLUSH_PC_OFS);
         inst_d   = NOP_INST;
         ctrl_d   = '0;
      end else if (load_i) begin
         valid_d  = 1'b1;
         bubble_d = kill_i;
         pc_d     = pc_i;
         inst_d   = inst_i;
         data_d   = data_i;
         ctrl_d   = kill_i ? '0 : ctrl_i;
      end else if (clr_i) begin
         valid_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         valid_q  <= 1'b0;
         bubble_q <= 1'b0;
         pc_q     <= '0;
         inst_q   <= '0;
         data_q   <= '0;
         ctrl_q   <= '0;
      end else begin
         valid_q  <= valid_d;
         bubble_q <= bubble_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         data_q   <= data_d;
         ctrl_q   <= ctrl_d;
      end
   end

   assign valid_o  = valid_q;
   assign bubble_o = bubble_q;
   assign pc_o     = pc_q;
   assign inst_o   = inst_q;
   assign data_o   = data_q;
   assign ctrl_o   = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with kill (bubble) and flush (redirect).
// Define PIPE_STAGE_SKID_EN to add a skid entry and make in_ready a registered signal.
module pipe_stage_reg #(
   parameter int PC_W   = pipe_pkg::PC_W,
   parameter int INST_W = pipe_pkg::INST_W,
   parameter int DATA_W = pipe_pkg::ID_EX_DATA_W,
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter logic [INST_W-1:0] NOP_INST = pipe_pkg::NOP_INST,
   parameter int FLUSH_PC_OFS = 2
) (
   input  logic              CLK,
   input  logic              NRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              kill,
   input  logic              flush,
   input  logic [PC_W-1:0]   flush_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_bubble
);
   import pipe_pkg::*;

   logic              acc, cons, main_ld;
   logic              src_kill;
   logic [PC_W-1:0]   src_pc;
   logic [INST_W-1:0] src_inst;
   logic [DATA_W-1:0] src_data;
   logic [CTRL_W-1:0] src_ctrl;

   assign acc  = in_valid & in_ready;
   assign cons = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_v, skid_bubble, skid_ld, skid_clr;
   logic [PC_W-1:0]   skid_pc;
   logic [INST_W-1:0] skid_inst;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   assign in_ready = ~skid_v;

   always_comb begin
      src_kill = kill;
      src_pc   = in_pc;
      src_inst = in_inst;
      src_data = in_data;
      src_ctrl = in_ctrl;
      main_ld  = 1'b0;
      if (skid_v) begin
         // Skid entry drains into main first so ordering is preserved.
         src_kill = skid_bubble;
         src_pc   = skid_pc;
         src_inst = skid_inst;
         src_data = skid_data;
         src_ctrl = skid_ctrl;
         main_ld  = cons;
      end else begin
         main_ld  = acc & (~out_valid | out_ready);
      end
      skid_ld  = ~flush & acc & out_valid & ~out_ready;
      skid_clr = flush | cons;
   end

   pipe_slot #(
      .PC_W(PC_W), .INST_W(INST_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W),
      .NOP_INST(NOP_INST), .FLUSH_PC_OFS(FLUSH_PC_OFS)
   ) u_skid (
      .CLK(CLK), .NRST(NRST),
      .load_i(skid_ld), .kill_i(kill), .flush_i(1'b0), .clr_i(skid_clr),
      .pc_i(in_pc), .inst_i(in_inst), .data_i(in_data), .ctrl_i(in_ctrl),
      .flush_pc_i(flush_pc),
      .valid_o(skid_v), .bubble_o(skid_bubble), .pc_o(skid_pc),
      .inst_o(skid_inst), .data_o(skid_data), .ctrl_o(skid_ctrl)
   );
`else
   assign in_ready = ~out_valid | out_ready;

   always_comb begin
      src_kill = kill;
      src_pc   = in_pc;
      src_inst = in_inst;
      src_data = in_data;
      src_ctrl = in_ctrl;
      main_ld  = acc;
   end
`endif

   pipe_slot #(
      .PC_W(PC_W), .INST_W(INST_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W),
      .NOP_INST(NOP_INST), .FLUSH_PC_OFS(FLUSH_PC_OFS)
   ) u_main (
      .CLK(CLK), .NRST(NRST),
      .load_i(main_ld), .kill_i(src_kill), .flush_i(flush), .clr_i(cons),
      .pc_i(src_pc), .inst_i(src_inst), .data_i(src_data), .ctrl_i(src_ctrl),
      .flush_pc_i(flush_pc),
      .valid_o(out_valid), .bubble_o(out_bubble), .pc_o(out_pc),
      .inst_o(out_inst), .data_o(out_data), .ctrl_o(out_ctrl)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random traffic against a queue-based model.
module tb_pipe_stage_reg;
   localparam int PC_W   = 13;
   localparam int INST_W = 32;
   localparam int DATA_W = 101;
   localparam int CTRL_W = 19;

   logic              CLK = 1'b0;
   logic              NRST;
   logic              in_valid, in_ready, kill, flush, out_valid, out_ready, out_bubble;
   logic [PC_W-1:0]   in_pc, flush_pc, out_pc;
   logic [INST_W-1:0] in_inst, out_inst;
   logic [DATA_W-1:0] in_data, out_data;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;

   always #5 CLK = ~CLK;

   pipe_stage_reg dut (
      .CLK(CLK), .NRST(NRST),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .in_data(in_data), .in_ctrl(in_ctrl),
      .kill(kill), .flush(flush), .flush_pc(flush_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .out_data(out_data), .out_ctrl(out_ctrl),
      .out_bubble(out_bubble)
   );

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
      logic [DATA_W-1:0] data;
      logic [CTRL_W-1:0] ctrl;
      logic              bubble;
   } ent_t;

   ent_t              q[$];
   logic [DATA_W-1:0] main_data;
   int                n_cmp = 0;
   int                n_err = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Occupancy limit of the stage as seen from upstream.
   function automatic bit exp_ready(input bit ordy);
`ifdef PIPE_STAGE_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || ordy;
`endif
   endfunction

   function automatic logic [DATA_W-1:0] rdata();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[DATA_W-1:0];
   endfunction

   task automatic check_out();
      chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
      if (q.size() > 0) begin
         chk("out_pc",     128'(out_pc),     128'(q[0].pc));
         chk("out_inst",   128'(out_inst),   128'(q[0].inst));
         chk("out_data",   128'(out_data),   128'(q[0].data));
         chk("out_ctrl",   128'(out_ctrl),   128'(q[0].ctrl));
         chk("out_bubble", 128'(out_bubble), 128'(q[0].bubble));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"},  128'(out_valid),  128'(0));
      chk({tag, "_bubble"}, 128'(out_bubble), 128'(0));
      chk({tag, "_pc"},     128'(out_pc),     128'(0));
      chk({tag, "_inst"},   128'(out_inst),   128'(0));
      chk({tag, "_data"},   128'(out_data),   128'(0));
      chk({tag, "_ctrl"},   128'(out_ctrl),   128'(0));
   endtask

   // One clock: drive inputs, check in_ready, advance the model at the edge, check outputs.
   task automatic cycle(input bit iv, input logic [PC_W-1:0] ipc, input logic [CTRL_W-1:0] ictrl,
                        input bit ikill, input bit ifl, input logic [PC_W-1:0] ifpc, input bit ordy);
      bit   rdy, acc, cons;
      ent_t e;
      logic [INST_W-1:0] iinst;
      logic [DATA_W-1:0] idata;
      iinst = $urandom();
      idata = rdata();
      in_valid = iv; in_pc = ipc; in_inst = iinst; in_data = idata; in_ctrl = ictrl;
      kill = ikill; flush = ifl; flush_pc = ifpc; out_ready = ordy;
      #1;
      rdy = exp_ready(ordy);
      chk("in_ready", 128'(in_ready), 128'(rdy));
      acc  = iv && rdy;
      cons = (q.size() > 0) && ordy;
      @(posedge CLK);
      #1;
      if (ifl) begin
         e.pc     = ifpc - PC_W'(2);
         e.inst   = 32'h0;
         e.data   = main_data;
         e.ctrl   = '0;
         e.bubble = 1'b1;
         q.delete();
         q.push_back(e);
      end else begin
         if (cons) void'(q.pop_front());
         if (acc) begin
            e.pc = ipc; e.inst = iinst; e.data = idata;
            e.ctrl = ikill ? '0 : ictrl;
            e.bubble = ikill;
            q.push_back(e);
         end
      end
      if (q.size() > 0) main_data = q[0].data;
      check_out();
   endtask

   task automatic idle(input bit ordy);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, ordy);
   endtask

   initial begin
      NRST = 1'b0;
      in_valid = 0; in_pc = '0; in_inst = '0; in_data = '0; in_ctrl = '0;
      kill = 0; flush = 0; flush_pc = '0; out_ready = 0;
      main_data = '0;
      repeat (2) @(posedge CLK);
      #1;
      check_zero("reset");
      chk("reset_in_ready", 128'(in_ready), 128'(1));
      @(negedge CLK);
      NRST = 1'b1;
      @(posedge CLK);
      #1;

      // Streaming at full rate
      cycle(1'b1, 13'h000, CTRL_W'($urandom()), 1'b0, 1'b0, '0, 1'b1);
      cycle(1'b1, 13'h004, CTRL_W'($urandom()), 1'b0, 1'b0, '0, 1'b1);
      cycle(1'b1, 13'h008, CTRL_W'($urandom()), 1'b0, 1'b0, '0, 1'b1);
      chk("stream_pc", 128'(out_pc), 128'(13'h008));

      // Asynchronous reset while an entry is valid
      in_valid = 1'b0;
      #3;
      NRST = 1'b0;
      #1;
      check_zero("async_rst");
      q.delete();
      main_data = '0;
      #1;
      NRST = 1'b1;
      @(posedge CLK);
      #1;
      cycle(1'b1, 13'h004, CTRL_W'($urandom()), 1'b0, 1'b0, '0, 1'b1);
      chk("post_rst_pc", 128'(out_pc), 128'(13'h004));
      idle(1'b1);

      // Backpressure: 0x010 held, 0x014 waits or goes to skid
      cycle(1'b1, 13'h010, CTRL_W'($urandom()), 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 13'h014, 19'h1234, 1'b0, 1'b0, '0, 1'b0);
         chk("bp_hold_pc", 128'(out_pc), 128'(13'h010));
      end
`ifdef PIPE_STAGE_SKID_EN
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
`else
      cycle(1'b1, 13'h014, 19'h1234, 1'b0, 1'b0, '0, 1'b1);
`endif
      chk("bp_release_pc", 128'(out_pc), 128'(13'h014));
      idle(1'b1);

      // Kill loads a bubble but keeps pc
      cycle(1'b1, 13'h020, 19'h7FFFF, 1'b1, 1'b0, '0, 1'b1);
      chk("kill_ctrl", 128'(out_ctrl), 128'(0));
      chk("kill_bubble", 128'(out_bubble), 128'(1));
      chk("kill_pc", 128'(out_pc), 128'(13'h020));

      // Flush beats kill and the incoming beat
      cycle(1'b1, 13'h030, CTRL_W'($urandom()), 1'b1, 1'b1, 13'h100, 1'b0);
      chk("flush_pc", 128'(out_pc), 128'(13'h0FE));
      chk("flush_inst", 128'(out_inst), 128'(0));
      chk("flush_bubble", 128'(out_bubble), 128'(1));
      idle(1'b1);

      // Flush to PC 0 wraps
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 13'h0000, 1'b1);
      chk("wrap_pc", 128'(out_pc), 128'(13'h1FFE));
      idle(1'b1);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         cycle(($urandom() % 4) != 0, PC_W'($urandom()), CTRL_W'($urandom()),
               ($urandom() % 5) == 0, ($urandom() % 16) == 0, PC_W'($urandom()),
               ($urandom() % 3) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
